// File: rtl/vx_lmem_remap_if.sv
// vx_lmem_remap_if: LSU memory bundle; master drives req_* and rsp_ready, slave drives req_ready and rsp_*
interface vx_lmem_remap_if #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FLAGS_W = 2,
  parameter int TAG_W = 8
);
  logic req_valid;
  logic req_rw;
  logic [NUM_LANES-1:0] req_mask;
  logic [NUM_LANES-1:0][DATA_W/8-1:0] req_byteen;
  logic [NUM_LANES-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_LANES-1:0][FLAGS_W-1:0] req_flags;
  logic [NUM_LANES-1:0][DATA_W-1:0] req_data;
  logic [TAG_W-1:0] req_tag;
  logic req_ready;
  logic rsp_valid;
  logic [NUM_LANES-1:0] rsp_mask;
  logic [NUM_LANES-1:0][DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_ready;
  modport master (
    output req_valid, req_rw, req_mask, req_byteen, req_addr, req_flags, req_data, req_tag,
    input req_ready,
    input rsp_valid, rsp_mask, rsp_data, rsp_tag,
    output rsp_ready
  );
  modport slave (
    input req_valid, req_rw, req_mask, req_byteen, req_addr, req_flags, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_mask, rsp_data, rsp_tag,
    input rsp_ready
  );
endinterface

// File: rtl/vx_lmem_remap.sv
// vx_lmem_remap: remaps local LSU lanes to base+offset in global memory (ports: clk, reset, lsu_in_if slave, lsu_out_if master, base_wr_valid/data/ready, busy; VX_LMEM_REMAP_PERF_EN adds perf_local_reqs, perf_stall_cycles)
module vx_lmem_remap #(
`ifdef VX_LMEM_REMAP_PERF_EN
  parameter int PERF_CTR_BITS = 32,
`endif
  parameter int NUM_LANES = 4,
  parameter int LSU_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FLAGS_WIDTH = 2,
  parameter int TAG_WIDTH = 8,
  parameter int MEM_REQ_FLAG_LOCAL = 1,
  parameter logic [LSU_ADDR_WIDTH-1:0] LMEM_BASE_ADDR = '0,
  parameter int LMEM_SIZE_LOG2 = 12,
  parameter int MAX_PENDING = 16
) (
  input logic clk,
  input logic reset,
  vx_lmem_remap_if.slave lsu_in_if,
  vx_lmem_remap_if.master lsu_out_if,
  input logic base_wr_valid,
  input logic [LSU_ADDR_WIDTH-1:0] base_wr_data,
  output logic base_wr_ready,
  output logic busy
`ifdef VX_LMEM_REMAP_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_local_reqs,
  output logic [PERF_CTR_BITS-1:0] perf_stall_cycles
`endif
);
  localparam int AW = LSU_ADDR_WIDTH;
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int PW1 = PW + 1;
  typedef enum logic [1:0] {IDLE, DRAIN, UPDATE} state_t;
  state_t state, state_n;
  logic [AW-1:0] base;
  logic [PW-1:0] pending;
  logic valid_q, rw_q;
  logic [NUM_LANES-1:0] mask_q;
  logic [NUM_LANES-1:0][DATA_WIDTH/8-1:0] byteen_q;
  logic [NUM_LANES-1:0][AW-1:0] addr_q, addr_remap;
  logic [NUM_LANES-1:0][FLAGS_WIDTH-1:0] flags_q;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic accepting, stall_pending, in_fire, out_fire, inc, dec;
  assign stall_pending = ({1'b0, pending} + PW1'(valid_q && !rw_q)) >= PW1'(MAX_PENDING);
  assign lsu_in_if.req_ready = !reset && accepting && (!valid_q || lsu_out_if.req_ready);
  assign in_fire = lsu_in_if.req_valid && lsu_in_if.req_ready;
  assign out_fire = valid_q && lsu_out_if.req_ready;
  assign inc = out_fire && !rw_q;
  assign dec = lsu_out_if.rsp_valid && lsu_out_if.rsp_ready;
  assign busy = pending != '0 || valid_q;
  always_comb
    for (int i = 0; i < NUM_LANES; i++)
      addr_remap[i] = lsu_in_if.req_flags[i][MEM_REQ_FLAG_LOCAL] ? base + AW'(lsu_in_if.req_addr[i][LMEM_SIZE_LOG2-1:0]) : lsu_in_if.req_addr[i];
  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else if (in_fire) valid_q <= 1'b1;
    else if (out_fire) valid_q <= 1'b0;
    if (in_fire) begin
      rw_q <= lsu_in_if.req_rw;
      mask_q <= lsu_in_if.req_mask;
      byteen_q <= lsu_in_if.req_byteen;
      addr_q <= addr_remap;
      flags_q <= lsu_in_if.req_flags;
      data_q <= lsu_in_if.req_data;
      tag_q <= lsu_in_if.req_tag;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else if (inc && !dec) pending <= pending + PW'(1);
    else if (dec && !inc && pending != '0) pending <= pending - PW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base <= LMEM_BASE_ADDR;
    end else begin
      state <= state_n;
      if (state == UPDATE) base <= base_wr_data;
    end
  end
  always_comb
    state_n = state == IDLE ? (base_wr_valid ? DRAIN : IDLE) :
              state == DRAIN ? ((!valid_q && pending == '0) ? UPDATE : DRAIN) : IDLE;
  always_comb begin
    accepting = state == IDLE && !base_wr_valid && !stall_pending;
    base_wr_ready = state == UPDATE;
  end
  assign lsu_out_if.req_valid = valid_q;
  assign lsu_out_if.req_rw = rw_q;
  assign lsu_out_if.req_mask = mask_q;
  assign lsu_out_if.req_byteen = byteen_q;
  assign lsu_out_if.req_addr = addr_q;
  assign lsu_out_if.req_flags = flags_q;
  assign lsu_out_if.req_data = data_q;
  assign lsu_out_if.req_tag = tag_q;
  assign lsu_in_if.rsp_valid = lsu_out_if.rsp_valid;
  assign lsu_in_if.rsp_mask = lsu_out_if.rsp_mask;
  assign lsu_in_if.rsp_data = lsu_out_if.rsp_data;
  assign lsu_in_if.rsp_tag = lsu_out_if.rsp_tag;
  assign lsu_out_if.rsp_ready = lsu_in_if.rsp_ready;
  assert property (@(posedge clk) disable iff (reset) !(dec && pending == '0));
`ifdef VX_LMEM_REMAP_PERF_EN
  logic [NUM_LANES-1:0] local_act;
  always_comb
    for (int i = 0; i < NUM_LANES; i++)
      local_act[i] = lsu_in_if.req_mask[i] && lsu_in_if.req_flags[i][MEM_REQ_FLAG_LOCAL];
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_local_reqs <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (in_fire && |local_act) perf_local_reqs <= perf_local_reqs + PERF_CTR_BITS'(1);
      if (lsu_in_if.req_valid && !accepting) perf_stall_cycles <= perf_stall_cycles + PERF_CTR_BITS'(1);
    end
  end
`endif
endmodule

// File: tb/tb_vx_lmem_remap.sv
// tb_vx_lmem_remap: directed vector table plus hand-written stall, drain, same-cycle and reset sequences for vx_lmem_remap
module tb_vx_lmem_remap;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic base_wr_valid = 1'b0;
  logic [31:0] base_wr_data = '0;
  logic base_wr_ready, busy;
  int checks = 0;
  int fails = 0;
  logic [165:0] exp_rest;
  logic [31:0] cur_base = 32'h4000;
  vx_lmem_remap_if #(.NUM_LANES(4), .ADDR_W(32), .DATA_W(32), .FLAGS_W(2), .TAG_W(8)) in_if ();
  vx_lmem_remap_if #(.NUM_LANES(4), .ADDR_W(32), .DATA_W(32), .FLAGS_W(2), .TAG_W(8)) out_if ();
`ifdef VX_LMEM_REMAP_PERF_EN
  logic [31:0] perf_a, perf_b;
`endif
  vx_lmem_remap #(.LMEM_BASE_ADDR(32'h4000), .LMEM_SIZE_LOG2(12), .MAX_PENDING(2)) dut (
    .clk(clk),
    .reset(reset),
    .lsu_in_if(in_if),
    .lsu_out_if(out_if),
    .base_wr_valid(base_wr_valid),
    .base_wr_data(base_wr_data),
    .base_wr_ready(base_wr_ready),
    .busy(busy)
`ifdef VX_LMEM_REMAP_PERF_EN
    ,
    .perf_local_reqs(perf_a),
    .perf_stall_cycles(perf_b)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] base;
    logic [3:0][31:0] addr;
    logic [3:0] loc;
    logic [3:0] mask;
    logic [3:0][31:0] exp;
  } vec_t;
  vec_t vt [7];
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic set_req(input logic [3:0][31:0] a, input logic [3:0] loc, input logic [3:0] m, input logic rw, input logic [7:0] tg);
    logic [3:0][1:0] fl;
    logic [3:0][31:0] dt;
    logic [3:0][3:0] be;
    for (int i = 0; i < 4; i++) begin
      fl[i] = {loc[i], tg[i]};
      dt[i] = {tg, 24'(i * 7 + 1)};
      be[i] = 4'(tg + 8'(i));
    end
    in_if.req_addr = a;
    in_if.req_flags = fl;
    in_if.req_mask = m;
    in_if.req_rw = rw;
    in_if.req_tag = tg;
    in_if.req_data = dt;
    in_if.req_byteen = be;
    in_if.req_valid = 1'b1;
    exp_rest = {1'b1, m, rw, be, fl, dt, tg};
  endtask
  task automatic push(input logic [3:0][31:0] a, input logic [3:0] loc, input logic [3:0] m, input logic rw, input logic [7:0] tg);
    int n = 0;
    set_req(a, loc, m, rw, tg);
    #1;
    while (!in_if.req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_if.req_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout tag=%0h actual=no_accept expected=accept", tg);
    end else @(posedge clk);
    @(negedge clk);
    in_if.req_valid = 1'b0;
  endtask
  task automatic upd(input logic [31:0] b);
    base_wr_valid = 1'b1;
    base_wr_data = b;
    #1;
    chk("upd_block_same_cycle", in_if.req_ready, 0);
    @(negedge clk);
    #1;
    chk("upd_drain_no_ready", base_wr_ready, 0);
    @(negedge clk);
    #1;
    chk("upd_pulse", base_wr_ready, 1);
    base_wr_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{base: 32'h4000, addr: {4{32'h1234}}, loc: 4'b0101, mask: 4'hF,
              exp: {32'h1234, 32'h4234, 32'h1234, 32'h4234}};
    vt[1] = '{base: 32'h4000, addr: {32'hABCDEFFF, 32'h00000FFF, 32'h77770001, 32'h00001000}, loc: 4'hF, mask: 4'hF,
              exp: {32'h4FFF, 32'h4FFF, 32'h4001, 32'h4000}};
    vt[2] = '{base: 32'h4000, addr: {32'h4, 32'h3, 32'h2, 32'h1}, loc: 4'h0, mask: 4'h3,
              exp: {32'h4, 32'h3, 32'h2, 32'h1}};
    vt[3] = '{base: 32'h4000, addr: {4{32'hDEADBEEF}}, loc: 4'b1000, mask: 4'h9,
              exp: {32'h4EEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}};
    vt[4] = '{base: 32'hFFFFF000, addr: {4{32'h12345FFF}}, loc: 4'hF, mask: 4'hF,
              exp: {4{32'hFFFFFFFF}}};
    vt[5] = '{base: 32'hFFFFFFFF, addr: {32'hFFF, 32'h0, 32'h1001, 32'h1}, loc: 4'hF, mask: 4'hF,
              exp: {32'hFFE, 32'hFFFFFFFF, 32'h0, 32'h0}};
    vt[6] = '{base: 32'h4000, addr: {4{32'h00000010}}, loc: 4'b0001, mask: 4'hF,
              exp: {32'h10, 32'h10, 32'h10, 32'h4010}};
    in_if.req_valid = 1'b1;
    in_if.req_rw = 1'b0;
    in_if.req_mask = '0;
    in_if.req_byteen = '0;
    in_if.req_addr = '0;
    in_if.req_flags = '0;
    in_if.req_data = '0;
    in_if.req_tag = '0;
    in_if.rsp_ready = 1'b1;
    out_if.req_ready = 1'b1;
    out_if.rsp_valid = 1'b0;
    out_if.rsp_mask = '0;
    out_if.rsp_data = '0;
    out_if.rsp_tag = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {in_if.req_ready, out_if.req_valid, base_wr_ready, busy}, 0);
    reset = 1'b0;
    in_if.req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      if (vt[k].base != cur_base) begin
        upd(vt[k].base);
        cur_base = vt[k].base;
      end
      push(vt[k].addr, vt[k].loc, vt[k].mask, 1'b1, 8'(k + 16));
      chk($sformatf("vec%0d_addr", k), out_if.req_addr, vt[k].exp);
      chk($sformatf("vec%0d_fields", k), {out_if.req_valid, out_if.req_mask, out_if.req_rw, out_if.req_byteen,
          out_if.req_flags, out_if.req_data, out_if.req_tag}, exp_rest);
    end
    set_req({4{32'hA0}}, 4'h0, 4'hF, 1'b0, 8'h31);
    #1;
    chk("stall_a_ready", in_if.req_ready, 1);
    @(negedge clk);
    set_req({4{32'hB0}}, 4'h0, 4'hF, 1'b0, 8'h32);
    #1;
    chk("stall_b_ready", in_if.req_ready, 1);
    chk("stall_a_out", {out_if.req_valid, out_if.req_rw, out_if.req_addr}, {2'b10, {4{32'hA0}}});
    @(negedge clk);
    set_req({4{32'hC0}}, 4'hF, 4'hF, 1'b0, 8'h33);
    #1;
    chk("stall_c_blocked", in_if.req_ready, 0);
    @(negedge clk);
    #1;
    chk("stall_full", {in_if.req_ready, out_if.req_valid, busy}, 3'b001);
    out_if.rsp_valid = 1'b1;
    out_if.rsp_mask = 4'hF;
    out_if.rsp_tag = 8'h31;
    out_if.rsp_data = {4{32'h5A5A0001}};
    #1;
    chk("rsp_passthrough", {in_if.rsp_valid, in_if.rsp_mask, in_if.rsp_tag, in_if.rsp_data},
        {1'b1, 4'hF, 8'h31, {4{32'h5A5A0001}}});
    @(negedge clk);
    out_if.rsp_valid = 1'b0;
    #1;
    chk("stall_c_resume", in_if.req_ready, 1);
    @(negedge clk);
    in_if.req_valid = 1'b0;
    chk("stall_c_out", {out_if.req_valid, out_if.req_addr}, {1'b1, {4{32'h40C0}}});
    @(negedge clk);
    out_if.rsp_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_if.rsp_valid = 1'b0;
    #1;
    chk("stall_idle_busy", busy, 0);
    in_if.rsp_ready = 1'b0;
    #1;
    chk("rsp_ready_low", out_if.rsp_ready, 0);
    in_if.rsp_ready = 1'b1;
    #1;
    chk("rsp_ready_high", out_if.rsp_ready, 1);
    @(negedge clk);
    set_req({4{32'h1000}}, 4'h0, 4'hF, 1'b0, 8'h41);
    @(negedge clk);
    set_req({4{32'h1004}}, 4'h0, 4'hF, 1'b0, 8'h42);
    @(negedge clk);
    set_req({4{32'h3000}}, 4'hF, 4'hF, 1'b1, 8'h43);
    base_wr_valid = 1'b1;
    base_wr_data = 32'h8000;
    #1;
    chk("drain_blocked", in_if.req_ready, 0);
    @(negedge clk);
    #1;
    chk("drain_c1", {base_wr_ready, in_if.req_ready}, 0);
    @(negedge clk);
    #1;
    chk("drain_c2", base_wr_ready, 0);
    out_if.rsp_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("drain_c3", base_wr_ready, 0);
    @(negedge clk);
    out_if.rsp_valid = 1'b0;
    #1;
    chk("drain_c4", base_wr_ready, 0);
    @(negedge clk);
    #1;
    chk("drain_pulse", {base_wr_ready, in_if.req_ready}, 2'b10);
    base_wr_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("drain_resume", in_if.req_ready, 1);
    @(negedge clk);
    in_if.req_valid = 1'b0;
    chk("drain_new_base", {out_if.req_valid, out_if.req_addr}, {1'b1, {4{32'h8000}}});
    @(negedge clk);
    set_req({4{32'h50}}, 4'h0, 4'hF, 1'b0, 8'h51);
    @(negedge clk);
    set_req({4{32'h54}}, 4'h0, 4'hF, 1'b1, 8'h52);
    @(negedge clk);
    in_if.req_valid = 1'b0;
    out_if.rsp_valid = 1'b1;
    #1;
    chk("same_cycle_before", {busy, out_if.req_valid, out_if.req_rw}, 3'b111);
    @(negedge clk);
    out_if.rsp_valid = 1'b0;
    #1;
    chk("same_cycle_after", {busy, in_if.req_ready}, 2'b01);
    @(negedge clk);
    set_req({4{32'h60}}, 4'h0, 4'hF, 1'b0, 8'h61);
    @(negedge clk);
    in_if.req_valid = 1'b0;
    @(negedge clk);
    base_wr_valid = 1'b1;
    base_wr_data = 32'h12340000;
    @(negedge clk);
    #1;
    chk("rst_drain_wait1", {base_wr_ready, busy}, 2'b01);
    @(negedge clk);
    #1;
    chk("rst_drain_wait2", base_wr_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_drain_state", {out_if.req_valid, base_wr_ready, busy, in_if.req_ready}, 0);
    reset = 1'b0;
    base_wr_valid = 1'b0;
    @(negedge clk);
    push({4{32'h00000010}}, 4'hF, 4'hF, 1'b1, 8'h71);
    chk("rst_base_restored", {base_wr_ready, out_if.req_addr}, {1'b0, {4{32'h4010}}});
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
